// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester (fetch/data) and memory-side signals of the
// shared memory port arbiter. 'slave' is the arbiter view; 'master' is the
// view of the core ports plus the memory they share.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // instruction-fetch port
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;

    // load/store port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    // shared single-port memory
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// instruction-fetch (I) and load/store (D) ports. One access at a time: grant
// in IDLE, wait MEM_LAT cycles, return data to the owner, back to IDLE.
// D has strict priority over I. Define MEM_ARB_STARVE_GUARD_EN to let I win
// a collision after STARVE_MAX consecutive D grants taken while I waited.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 3;
    localparam int unsigned SC_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    // Reject out-of-range configurations at elaboration
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT must be 1..4");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be 1..15");
    end

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    owner_t           r_owner, w_owner_nxt;
    logic             r_store, w_store_nxt;

    logic             w_pick_i;
    logic             w_i_gnt, w_i_rvalid, w_d_gnt, w_d_rvalid;
    logic [DW-1:0]    w_i_rdata, w_d_rdata;
    logic             w_mem_en, w_mem_we, w_busy;
    logic [AW-1:0]    w_mem_addr;
    logic [DW-1:0]    w_mem_wdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
    logic [SC_W-1:0] r_starve;

    // I wins when alone, or on a collision once D has hit the starvation limit
    assign w_pick_i = bus.i_req && (!bus.d_req || (r_starve == STARVE_LIM));

    // Count D grants taken while I waits; any I grant or uncontested D grant clears
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_i_gnt) begin
            r_starve <= '0;
        end else if (w_d_gnt) begin
            if (bus.i_req) begin
                r_starve <= (r_starve == STARVE_LIM) ? r_starve : r_starve + SC_W'(1);
            end else begin
                r_starve <= '0;
            end
        end
    end
`else
    // Strict D priority: I only wins when D is not requesting
    assign w_pick_i = bus.i_req && !bus.d_req;
`endif

    // State, latency counter and owner registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_owner <= OWN_I;
            r_store <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
            r_store <= w_store_nxt;
        end
    end

    // Grant/issue in IDLE, count down and route the response in WAIT
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_store_nxt = r_store;
        w_i_gnt     = 1'b0;
        w_i_rvalid  = 1'b0;
        w_i_rdata   = '0;
        w_d_gnt     = 1'b0;
        w_d_rvalid  = 1'b0;
        w_d_rdata   = '0;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_busy      = 1'b0;

        case (r_state)
            IDLE: begin
                // no grants while reset is held, so outputs stay quiet
                if (rst && (bus.i_req || bus.d_req)) begin
                    w_mem_en    = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = WAIT;
                    if (w_pick_i) begin
                        w_i_gnt     = 1'b1;
                        w_mem_addr  = bus.i_addr;
                        w_owner_nxt = OWN_I;
                        w_store_nxt = 1'b0;
                    end else begin
                        w_d_gnt     = 1'b1;
                        w_mem_we    = bus.d_we;
                        w_mem_addr  = bus.d_addr;
                        w_mem_wdata = bus.d_wdata;
                        w_owner_nxt = OWN_D;
                        w_store_nxt = bus.d_we;
                    end
                end
            end
            WAIT: begin
                w_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    if (r_owner == OWN_I) begin
                        w_i_rvalid = 1'b1;
                        w_i_rdata  = bus.mem_rdata;
                    end else begin
                        w_d_rvalid = 1'b1;
                        w_d_rdata  = r_store ? '0 : bus.mem_rdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.i_gnt     = w_i_gnt;
    assign bus.i_rvalid  = w_i_rvalid;
    assign bus.i_rdata   = w_i_rdata;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.d_rvalid  = w_d_rvalid;
    assign bus.d_rdata   = w_d_rdata;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.busy      = w_busy;
endmodule
